// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: write-back select encodings
// and the MEM-stage load/store unit state type.
package mips_pkg;

    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_MEM  = 2'b01;
    localparam logic [1:0] MTR_LINK = 2'b10;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_REQ  = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Saturating up-counter that flags when a memory request has waited
// TIMEOUT-1 cycles without an acknowledge.
module lsu_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit with req/ack data-memory handshake, misalign and
// time-out detection, and the MEM/WB pipeline register.
module mem_stage_lsu
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Mem_in,
    input  logic [31:0] Mem_BusB,
    input  logic        Mem_MemRd,
    input  logic        Mem_MemWr,
    input  logic        Mem_RegWr,
    input  logic [1:0]  Mem_MemtoReg,
    input  logic [4:0]  Mem_WrReg,
    input  logic [31:0] Mem_PC,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        WB_RegWr,
    output logic [4:0]  WB_WrReg,
    output logic [31:0] WB_Data,
    output logic        exc_misalign,
    output logic        exc_buserr
);
    lsu_state_t  state;
    logic        access;
    logic        misaligned;
    logic        aligned_acc;
    logic        in_req;
    logic        expired;
    logic [31:0] wb_sel;

    assign access      = Mem_MemRd | Mem_MemWr;
    assign misaligned  = access & (|Mem_in[1:0]);
    assign aligned_acc = access & ~(|Mem_in[1:0]);
    assign in_req      = (state == LSU_REQ);

    assign dm_req    = in_req;
    assign mem_stall = ((state == LSU_IDLE) & aligned_acc) | (in_req & ~dm_ack & ~expired);

    always_comb begin
        case (Mem_MemtoReg)
            MTR_MEM:  wb_sel = dm_rdata;
            MTR_LINK: wb_sel = Mem_PC;
            default:  wb_sel = Mem_in;
        endcase
    end

    lsu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == LSU_IDLE),
        .enable  (in_req & ~dm_ack),
        .expired (expired)
    );

    // MEM/WB only ever captures the instruction on the cycle it leaves MEM;
    // every other cycle it takes a zeroed bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LSU_IDLE;
            dm_we        <= 1'b0;
            dm_addr      <= '0;
            dm_wdata     <= '0;
            WB_RegWr     <= 1'b0;
            WB_WrReg     <= '0;
            WB_Data      <= '0;
            exc_misalign <= 1'b0;
            exc_buserr   <= 1'b0;
        end else begin
            exc_misalign <= (state == LSU_IDLE) & misaligned;
            exc_buserr   <= in_req & ~dm_ack & expired;
            WB_RegWr     <= 1'b0;
            WB_WrReg     <= '0;
            WB_Data      <= '0;
            case (state)
                LSU_IDLE: begin
                    if (aligned_acc) begin
                        state    <= LSU_REQ;
                        dm_we    <= Mem_MemWr;
                        dm_addr  <= {Mem_in[31:2], 2'b00};
                        dm_wdata <= Mem_BusB;
                    end else if (!misaligned) begin
                        WB_RegWr <= Mem_RegWr;
                        WB_WrReg <= Mem_WrReg;
                        WB_Data  <= wb_sel;
                    end
                end
                LSU_REQ: begin
                    if (dm_ack) begin
                        state    <= LSU_IDLE;
                        WB_RegWr <= Mem_RegWr;
                        WB_WrReg <= Mem_WrReg;
                        WB_Data  <= wb_sel;
                    end else if (expired) begin
                        state <= LSU_IDLE;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// instruction streams against a per-instruction behavioural model.
module tb_mem_stage_lsu;
    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic [31:0] Mem_in;
    logic [31:0] Mem_BusB;
    logic        Mem_MemRd;
    logic        Mem_MemWr;
    logic        Mem_RegWr;
    logic [1:0]  Mem_MemtoReg;
    logic [4:0]  Mem_WrReg;
    logic [31:0] Mem_PC;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_stall;
    logic        WB_RegWr;
    logic [4:0]  WB_WrReg;
    logic [31:0] WB_Data;
    logic        exc_misalign;
    logic        exc_buserr;

    mem_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .Mem_in       (Mem_in),
        .Mem_BusB     (Mem_BusB),
        .Mem_MemRd    (Mem_MemRd),
        .Mem_MemWr    (Mem_MemWr),
        .Mem_RegWr    (Mem_RegWr),
        .Mem_MemtoReg (Mem_MemtoReg),
        .Mem_WrReg    (Mem_WrReg),
        .Mem_PC       (Mem_PC),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_ack       (dm_ack),
        .dm_rdata     (dm_rdata),
        .mem_stall    (mem_stall),
        .WB_RegWr     (WB_RegWr),
        .WB_WrReg     (WB_WrReg),
        .WB_Data      (WB_Data),
        .exc_misalign (exc_misalign),
        .exc_buserr   (exc_buserr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // Expected registered outputs for the current cycle.
    logic        exp_regwr;
    logic [4:0]  exp_wrreg;
    logic [31:0] exp_data;
    logic        exp_mis;
    logic        exp_bus;

    // Stimulus knobs: ack value outside REQ (random or forced high), fixed read data.
    bit          idle_ack_high = 1'b0;
    bit          use_fix_rdata = 1'b0;
    logic [31:0] fix_rdata     = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wb_value(input logic [1:0] mtr, input logic [31:0] alu,
                                             input logic [31:0] rdata, input logic [31:0] pc);
        if (mtr == 2'b01) return rdata;
        if (mtr == 2'b10) return pc;
        return alu;
    endfunction

    task automatic check_wb();
        chk("wb_regwr", {31'b0, WB_RegWr}, {31'b0, exp_regwr});
        chk("exc_misalign", {31'b0, exc_misalign}, {31'b0, exp_mis});
        chk("exc_buserr", {31'b0, exc_buserr}, {31'b0, exp_bus});
        if (exp_regwr) begin
            chk("wb_wrreg", {27'b0, WB_WrReg}, {27'b0, exp_wrreg});
            chk("wb_data", WB_Data, exp_data);
        end
    endtask

    // Runs one instruction through MEM. Entered and left 1 time unit after a posedge.
    // ack_at: REQ cycle index (0-based) in which memory acks; >= TIMEOUT means never.
    task automatic run_instr(input logic rd, input logic wr, input logic regwr,
                             input logic [1:0] mtr, input logic [4:0] wrreg,
                             input logic [31:0] addr, input logic [31:0] busb,
                             input logic [31:0] pc, input int ack_at,
                             output int stall_cycles, output int req_cycles);
        bit is_mem, mis, go, ack_now, tmo, exp_stall, exp_req;
        logic [31:0] rv;
        is_mem = rd | wr;
        mis    = is_mem && (addr[1:0] != 2'b00);
        go     = is_mem && !mis;
        stall_cycles = 0;
        req_cycles   = 0;
        Mem_MemRd = rd; Mem_MemWr = wr; Mem_RegWr = regwr; Mem_MemtoReg = mtr;
        Mem_WrReg = wrreg; Mem_in = addr; Mem_BusB = busb; Mem_PC = pc;
        for (int k = 0; k < 40; k++) begin
            ack_now = go && (k >= 1) && ((k - 1) == ack_at);
            tmo     = go && (k >= 1) && ((k - 1) == TIMEOUT - 1) && !ack_now;
            rv      = use_fix_rdata ? fix_rdata : $urandom;
            if (go && k >= 1) dm_ack = ack_now;
            else              dm_ack = idle_ack_high ? 1'b1 : 1'($urandom_range(0, 1));
            dm_rdata = rv;
            #3;
            exp_stall = go && ((k == 0) || (!ack_now && !tmo));
            exp_req   = go && (k >= 1);
            chk("mem_stall", {31'b0, mem_stall}, {31'b0, exp_stall});
            chk("dm_req", {31'b0, dm_req}, {31'b0, exp_req});
            if (exp_req) begin
                chk("dm_we", {31'b0, dm_we}, {31'b0, wr});
                chk("dm_addr", dm_addr, {addr[31:2], 2'b00});
                chk("dm_wdata", dm_wdata, busb);
            end
            check_wb();
            stall_cycles += int'(mem_stall);
            req_cycles   += int'(dm_req);
            exp_mis = 1'b0;
            exp_bus = 1'b0;
            if (!is_mem || ack_now) begin
                exp_regwr = regwr;
                exp_wrreg = wrreg;
                exp_data  = wb_value(mtr, addr, rv, pc);
            end else begin
                exp_regwr = 1'b0;
                exp_mis   = mis;
                exp_bus   = tmo;
            end
            @(posedge clk);
            #1;
            if (!exp_stall) return;
        end
    endtask

    int s, r;
    logic [1:0] mtr_r;
    logic [31:0] addr_r;
    int typ, ack_r;
    logic rd_r, wr_r;

    initial begin
        reset = 1'b1;
        Mem_in = '0; Mem_BusB = '0; Mem_MemRd = 1'b0; Mem_MemWr = 1'b0; Mem_RegWr = 1'b0;
        Mem_MemtoReg = 2'b00; Mem_WrReg = '0; Mem_PC = '0; dm_ack = 1'b0; dm_rdata = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #3;
        chk("rst_dm_req", {31'b0, dm_req}, 32'd0);
        chk("rst_mem_stall", {31'b0, mem_stall}, 32'd0);
        chk("rst_wb_regwr", {31'b0, WB_RegWr}, 32'd0);
        chk("rst_wb_wrreg", {27'b0, WB_WrReg}, 32'd0);
        chk("rst_wb_data", WB_Data, 32'd0);
        chk("rst_exc", {30'b0, exc_misalign, exc_buserr}, 32'd0);
        exp_regwr = 1'b0; exp_wrreg = '0; exp_data = '0; exp_mis = 1'b0; exp_bus = 1'b0;
        @(posedge clk);
        #1;

        // ALU op
        run_instr(1'b0, 1'b0, 1'b1, 2'b00, 5'd5, 32'h1234, 32'h0, 32'h100, 0, s, r);
        chk("alu_stall_cycles", s, 0);
        chk("alu_wb_data", WB_Data, 32'h1234);
        chk("alu_wb_wrreg", {27'b0, WB_WrReg}, 32'd5);
        chk("alu_wb_regwr", {31'b0, WB_RegWr}, 32'd1);

        // Load with ack in the 4th REQ cycle
        use_fix_rdata = 1'b1; fix_rdata = 32'hDEADBEEF;
        run_instr(1'b1, 1'b0, 1'b1, 2'b01, 5'd9, 32'h40, 32'h0, 32'h104, 3, s, r);
        use_fix_rdata = 1'b0;
        chk("load_stall_cycles", s, 4);
        chk("load_req_cycles", r, 4);
        chk("load_wb_data", WB_Data, 32'hDEADBEEF);
        chk("load_wb_regwr", {31'b0, WB_RegWr}, 32'd1);
        run_instr(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 0, s, r);
        chk("load_single_pulse", {31'b0, WB_RegWr}, 32'd0);

        // Store with immediate ack, then back-to-back load
        run_instr(1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 32'h44, 32'hA5A5A5A5, 32'h0, 0, s, r);
        chk("store_req_cycles", r, 1);
        chk("store_wb_regwr", {31'b0, WB_RegWr}, 32'd0);
        run_instr(1'b1, 1'b0, 1'b1, 2'b01, 5'd3, 32'h48, 32'h0, 32'h0, 1, s, r);
        chk("b2b_load_stall_cycles", s, 2);

        // Misaligned load
        run_instr(1'b1, 1'b0, 1'b1, 2'b01, 5'd7, 32'h42, 32'h0, 32'h0, 0, s, r);
        chk("mis_req_cycles", r, 0);
        chk("mis_stall_cycles", s, 0);
        chk("mis_exc", {31'b0, exc_misalign}, 32'd1);
        chk("mis_wb_regwr", {31'b0, WB_RegWr}, 32'd0);

        // Time-out, then a late ack that must be ignored
        run_instr(1'b1, 1'b0, 1'b1, 2'b01, 5'd8, 32'h50, 32'h0, 32'h0, 100, s, r);
        chk("tmo_req_cycles", r, 16);
        chk("tmo_exc", {31'b0, exc_buserr}, 32'd1);
        chk("tmo_wb_regwr", {31'b0, WB_RegWr}, 32'd0);
        idle_ack_high = 1'b1;
        run_instr(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 0, s, r);
        run_instr(1'b0, 1'b0, 1'b1, 2'b10, 5'd4, 32'h0, 32'h0, 32'h200, 0, s, r);
        idle_ack_high = 1'b0;
        chk("late_ack_req_cycles", r, 0);

        // Reset in the 2nd REQ cycle
        Mem_MemRd = 1'b1; Mem_MemWr = 1'b0; Mem_RegWr = 1'b1; Mem_MemtoReg = 2'b01;
        Mem_WrReg = 5'd6; Mem_in = 32'h80; dm_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        Mem_MemRd = 1'b0; Mem_RegWr = 1'b0;
        #3;
        chk("mid_rst_dm_req", {31'b0, dm_req}, 32'd0);
        chk("mid_rst_mem_stall", {31'b0, mem_stall}, 32'd0);
        chk("mid_rst_wb_regwr", {31'b0, WB_RegWr}, 32'd0);
        chk("mid_rst_wb_wrreg", {27'b0, WB_WrReg}, 32'd0);
        chk("mid_rst_wb_data", WB_Data, 32'd0);
        exp_regwr = 1'b0; exp_wrreg = '0; exp_data = '0; exp_mis = 1'b0; exp_bus = 1'b0;
        @(posedge clk);
        #1;

        // Randomized instruction stream
        for (int i = 0; i < 250; i++) begin
            typ = $urandom_range(0, 9);
            addr_r = $urandom;
            ack_r = $urandom_range(0, 5);
            if (typ < 4) begin
                rd_r = 1'b0; wr_r = 1'b0;
                case ($urandom_range(0, 2))
                    0:       mtr_r = 2'b00;
                    1:       mtr_r = 2'b10;
                    default: mtr_r = 2'b11;
                endcase
            end else begin
                {rd_r, wr_r} = 2'($urandom_range(1, 3));
                mtr_r = 2'($urandom_range(0, 3));
                if (typ == 4) addr_r[1:0] = 2'($urandom_range(1, 3));
                else          addr_r[1:0] = 2'b00;
                if (typ == 9) ack_r = $urandom_range(14, 20);
            end
            run_instr(rd_r, wr_r, 1'($urandom_range(0, 1)), mtr_r, 5'($urandom),
                      addr_r, $urandom, $urandom, ack_r, s, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

MEM-stage load/store unit and MEM/WB pipeline register of the pipelined MIPS core. It consumes the Mem_* fields held in the EX/MEM register and runs a req/ack handshake to data memory. It stalls everything upstream while an access is outstanding, then loads the selected write-back value into its MEM/WB register. It also detects misaligned word accesses and memory time-outs.

## Interface
- TIMEOUT, 16: maximum REQ cycles without dm_ack before the access is aborted (≥2).
- clk  in  1  core clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- Mem_in  in  32  ALU result; the byte address for loads/stores.
- Mem_BusB  in  32  store data.
- Mem_MemRd, Mem_MemWr  in  1  load / store request.
- Mem_RegWr  in  1  register write enable of the instruction.
- Mem_MemtoReg  in  2  write-back select: 00 ALU, 01 load data, 10 link (Mem_PC), 11 treated as 00.
- Mem_WrReg  in  5  destination register.
- Mem_PC  in  32  link value (already PC+4).
- dm_req  out  1  memory request.
- dm_we  out  1  1 = store.
- dm_addr  out  32  word address; bits [1:0] forced to 0.
- dm_wdata  out  32  store data.
- dm_ack  in  1  memory completion, sampled only while dm_req=1.
- dm_rdata  in  32  load data, valid with dm_ack.
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- WB_RegWr  out  1  registered write enable.
- WB_WrReg  out  5  registered destination register.
- WB_Data  out  32  registered write-back value.
- exc_misalign  out  1  one-cycle pulse: misaligned access squashed.
- exc_buserr  out  1  one-cycle pulse: time-out abort.

## Operation
- States: IDLE, REQ.
- access = Mem_MemRd | Mem_MemWr. If both are set, the access is a store.
- IDLE, no access: MEM/WB loads {Mem_RegWr, Mem_WrReg, selected data}. mem_stall=0.
- IDLE, access with Mem_in[1:0]≠0:
  - No request is issued; mem_stall=0.
  - MEM/WB loads a bubble (WB_RegWr=0).
  - exc_misalign is 1 in the following cycle.
- IDLE, aligned access: mem_stall=1, MEM/WB loads a bubble, next state REQ, timeout counter cleared.
- REQ:
  - dm_req=1. dm_we, dm_addr and dm_wdata are driven from the held Mem_* fields.
  - Counter increments each cycle without dm_ack.
- REQ with dm_ack=1:
  - mem_stall=0 in that same cycle, so EX/MEM advances at the edge.
  - MEM/WB loads the instruction: WB_Data = dm_rdata when Mem_MemtoReg=01.
  - A store loads WB_RegWr = Mem_RegWr (0 from decode).
  - Next state IDLE.
- REQ, counter = TIMEOUT-1 and no ack:
  - mem_stall=0, MEM/WB loads a bubble, next state IDLE.
  - exc_buserr pulses in the following cycle.
  - dm_req drops at that edge; a late ack is ignored because dm_req=0.
- While stalling, MEM/WB holds bubbles, never duplicates of the stalled instruction.

## Timing
- Reset: state IDLE, counter 0, WB_RegWr=0, WB_WrReg=0, WB_Data=0, exc_*=0.
  - dm_req=0 from the reset edge, including reset during REQ; the in-flight access is abandoned.
- Non-memory instruction: 1 cycle in MEM, no stall.
- Load/store with ack in the first REQ cycle: 2 cycles in MEM, 1 stall cycle.
- In general: 1 + N cycles, where N is the number of REQ cycles (ack or abort, N ≤ TIMEOUT).
- mem_stall and dm_req are combinational from state, access and dm_ack. No other output depends combinationally on inputs.
- Back-to-back memory instructions: the second enters IDLE the cycle after the first completes and issues normally; there is no idle cycle between requests.
- Counter width is clog2(TIMEOUT). It saturates and never wraps.

## Structure
- Shared package mips_pkg holds:
  - MemtoReg encodings (MTR_ALU=2'b00, MTR_MEM=2'b01, MTR_LINK=2'b10).
  - The LSU state enum.
- One natural sub-module: lsu_timeout_ctr (clear, enable, expired flag at TIMEOUT-1).
- The write-back mux is inline.

## Test plan
- Reset, then ALU op Mem_in=32'h1234, MemtoReg=00, WrReg=5, RegWr=1 → next cycle WB_Data=32'h1234, WB_WrReg=5, WB_RegWr=1, mem_stall never 1.
- Load addr 32'h40 with ack 3 cycles after dm_req rises, rdata=32'hDEADBEEF:
  - mem_stall high for 4 cycles; dm_addr=32'h40, dm_we=0.
  - Then WB_Data=32'hDEADBEEF and exactly one WB_RegWr=1 pulse.
- Store addr 32'h44, BusB=32'hA5A5A5A5 with immediate ack, followed by a load → dm_we=1 with matching wdata, then a second request with no idle gap; store gives WB_RegWr=0.
- Load addr 32'h42 → no dm_req, exc_misalign one cycle, WB_RegWr=0, mem_stall=0.
- Load with dm_ack held low, TIMEOUT=16 → dm_req high exactly 16 cycles, exc_buserr one pulse, WB_RegWr=0; an ack asserted afterwards has no effect.
- Reset asserted in the 2nd REQ cycle → next cycle dm_req=0, mem_stall=0, all WB outputs 0.
